bf16_add_sequencer: RTL and testbench

- Initiator-side sequencer for the bfloat16 adder.
- Accepts operand pairs from a producer over a valid/ready handshake.
- Drives the adder's a/b inputs and holds them stable until the adder's single-cycle ready pulse returns a result.
- Presents each result to a consumer over a valid/ready handshake. One operation is outstanding at a time.

---
 rtl/bf16_add_sequencer.sv | 147 ++++++++++++++
 tb/tb_bf16_add_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_add_sequencer.sv
// rtl/bf16_add_sequencer.sv - issue/hold/collect sequencer for one outstanding bfloat16 add
// Optional WAIT-state watchdog enabled by defining BF16_SEQ_TIMEOUT_EN.
module bf16_add_sequencer #(
  parameter int SETTLE_CYC = 3,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             in_valid,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             in_ready,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  input  logic             add_ready,
  output logic             out_valid,
  output logic [15:0]      out_sum,
  output logic             out_err,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, HOLD} state_t;

  localparam int              SC_W        = $clog2(SETTLE_CYC + 1);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYC - 1);

  if (SETTLE_CYC < 1 || TIMEOUT < 1) begin : g_param_check
    $error("bf16_add_sequencer: SETTLE_CYC and TIMEOUT must be at least 1");
  end

  state_t          state, state_nxt;
  logic [SC_W-1:0] settle_cnt;
  logic            load, capture, retire;

`ifdef BF16_SEQ_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            expire;
  logic            err_q;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
`ifdef BF16_SEQ_TIMEOUT_EN
    expire    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = WAIT;
      end
      WAIT: begin
        // A real result always beats the watchdog on the same cycle.
        if (add_ready) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
`ifdef BF16_SEQ_TIMEOUT_EN
        else if (wd_cnt == WD_LAST) begin
          expire    = 1'b1;
          state_nxt = HOLD;
        end
`endif
      end
      HOLD: begin
        if (out_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      add_a      <= '0;
      add_b      <= '0;
      settle_cnt <= '0;
      out_sum    <= '0;
      out_valid  <= 1'b0;
      op_count   <= '0;
    end else begin
      if (load) begin
        add_a      <= in_a;
        add_b      <= in_b;
        settle_cnt <= '0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (capture) begin
        out_sum   <= add_sum;
        out_valid <= 1'b1;
      end
`ifdef BF16_SEQ_TIMEOUT_EN
      if (expire) begin
        out_sum   <= 16'hFFFF;
        out_valid <= 1'b1;
      end
`endif
      if (retire) begin
        out_valid <= 1'b0;
        op_count  <= op_count + 1'b1;
      end
    end
  end

`ifdef BF16_SEQ_TIMEOUT_EN
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
      else               wd_cnt <= '0;
      if (capture)     err_q <= 1'b0;
      else if (expire) err_q <= 1'b1;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bf16_add_sequencer.sv
// tb/tb_bf16_add_sequencer.sv - directed self-checking bench for bf16_add_sequencer
module tb_bf16_add_sequencer;

  localparam int SC = 3;
  localparam int TO = 64;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_a = '0;
  logic [15:0]   in_b = '0;
  logic          in_ready;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic [15:0]   add_sum = '0;
  logic          add_ready = 1'b0;
  logic          out_valid;
  logic [15:0]   out_sum;
  logic          out_err;
  logic          out_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] op_count;

  int n_cmp = 0;
  int n_bad = 0;

  bf16_add_sequencer #(.SETTLE_CYC(SC), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_ready (add_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_err   (out_err),
    .out_ready (out_ready),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (SC) step();
  endtask

  task automatic pulse(input logic [15:0] s);
    add_ready = 1'b1;
    add_sum   = s;
    step();
    add_ready = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen_valid;
    logic [15:0] exp_sum;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_sum", out_sum, 16'h0000);
    chk("rst_add_a", add_a, 16'h0000);
    chk("rst_op_count", 16'(op_count), 16'h0);
    nreset = 1'b1;
    step();

    // 1: basic add, result three cycles after WAIT entry
    issue(16'h3F80, 16'h3F80);
    chk("t1_add_a", add_a, 16'h3F80);
    chk("t1_add_b", add_b, 16'h3F80);
    chk("t1_busy", 16'(busy), 16'h1);
    chk("t1_in_ready", 16'(in_ready), 16'h0);
    settle();
    repeat (3) step();
    chk("t1_wait_no_valid", 16'(out_valid), 16'h0);
    pulse(16'h4000);
    chk("t1_out_valid", 16'(out_valid), 16'h1);
    chk("t1_out_sum", out_sum, 16'h4000);
    chk("t1_out_err", 16'(out_err), 16'h0);
    chk("t1_count_before", 16'(op_count), 16'h0);
    accept();
    chk("t1_out_valid_clr", 16'(out_valid), 16'h0);
    chk("t1_op_count", 16'(op_count), 16'h1);
    chk("t1_idle", 16'(in_ready), 16'h1);

    // 2: pulses during SETTLE are discarded
    issue(16'h4000, 16'h3F80);
    add_ready = 1'b1;
    add_sum   = 16'h1234;
    settle();
    add_ready = 1'b0;
    step();
    chk("t2_settle_ignored", 16'(out_valid), 16'h0);
    pulse(16'h4040);
    chk("t2_out_valid", 16'(out_valid), 16'h1);
    chk("t2_out_sum", out_sum, 16'h4040);
    accept();
    chk("t2_op_count", 16'(op_count), 16'h2);

    // 3: stall in HOLD with add_ready and in_valid active
    issue(16'h4000, 16'h3F80);
    settle();
    pulse(16'h40A0);
    in_valid  = 1'b1;
    in_a      = 16'h1111;
    in_b      = 16'h2222;
    add_ready = 1'b1;
    add_sum   = 16'hDEAD;
    repeat (10) step();
    chk("t3_sum_stable", out_sum, 16'h40A0);
    chk("t3_valid_held", 16'(out_valid), 16'h1);
    chk("t3_in_ready", 16'(in_ready), 16'h0);
    chk("t3_add_a_held", add_a, 16'h4000);
    chk("t3_add_b_held", add_b, 16'h3F80);
    add_ready = 1'b0;
    accept();
    chk("t3_idle", 16'(in_ready), 16'h1);
    chk("t3_no_same_cycle_accept", add_a, 16'h4000);
    chk("t3_op_count", 16'(op_count), 16'h3);
    step();
    in_valid = 1'b0;
    chk("t3_pending_a", add_a, 16'h1111);
    chk("t3_pending_b", add_b, 16'h2222);
    chk("t3_busy", 16'(busy), 16'h1);
    settle();
    pulse(16'h3333);
    chk("t3_second_sum", out_sum, 16'h3333);
    accept();
    issue(16'h0001, 16'h0002);
    settle();
    pulse(16'h0003);
    accept();
    chk("t3_op_count5", 16'(op_count), 16'h5);

    // 4: asynchronous reset while in WAIT
    issue(16'h5555, 16'h6666);
    settle();
    chk("t4_in_wait", 16'(busy), 16'h1);
    #2;
    nreset = 1'b0;
    #1;
    chk("t4_async_count", 16'(op_count), 16'h0);
    chk("t4_async_add_a", add_a, 16'h0000);
    chk("t4_async_add_b", add_b, 16'h0000);
    chk("t4_async_busy", 16'(busy), 16'h0);
    chk("t4_async_in_ready", 16'(in_ready), 16'h1);
    chk("t4_async_valid", 16'(out_valid), 16'h0);
    step();
    nreset = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      add_ready = i[0];
      add_sum   = 16'h7777;
      step();
      seen_valid = seen_valid | out_valid;
    end
    add_ready = 1'b0;
    chk("t4_no_result", 16'(seen_valid), 16'h0);
    chk("t4_still_idle", 16'(busy), 16'h0);

    // 5: watchdog (or indefinite wait when it is not built)
`ifdef BF16_SEQ_TIMEOUT_EN
    issue(16'h3F80, 16'h4000);
    settle();
    repeat (TO - 1) step();
    chk("t5_before_timeout", 16'(out_valid), 16'h0);
    step();
    chk("t5_timeout_valid", 16'(out_valid), 16'h1);
    chk("t5_timeout_sum", out_sum, 16'hFFFF);
    chk("t5_timeout_err", 16'(out_err), 16'h1);
    accept();
    issue(16'h3F80, 16'h4000);
    settle();
    repeat (TO - 1) step();
    pulse(16'h4100);
    chk("t5_tie_valid", 16'(out_valid), 16'h1);
    chk("t5_tie_sum", out_sum, 16'h4100);
    chk("t5_tie_err", 16'(out_err), 16'h0);
    accept();
`else
    issue(16'h3F80, 16'h4000);
    settle();
    repeat (100) step();
    chk("t5_no_timeout", 16'(out_valid), 16'h0);
    chk("t5_still_busy", 16'(busy), 16'h1);
    pulse(16'h4100);
    chk("t5_late_sum", out_sum, 16'h4100);
    chk("t5_err_tied", 16'(out_err), 16'h0);
    accept();
`endif

    // 6: op_count wraps modulo 2^CW
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    step();
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      exp_sum = 16'(16'h4000 + i);
      issue(16'h3C00, 16'h3C00);
      settle();
      pulse(exp_sum);
      chk($sformatf("t6_sum_%0d", i), out_sum, exp_sum);
      accept();
      if (i == (1 << CW) - 1) chk("t6_wrap_zero", 16'(op_count), 16'h0);
    end
    chk("t6_wrap_one", 16'(op_count), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
